mmio_de10: RTL and testbench

- Memory-mapped I/O peripheral on the RV32IM single-cycle core's data bus, in parallel with data RAM.
- Decodes `data_addr`/`mem_write`/`write_data` and owns the DE10-Lite LEDR, HEX0-5 and SW pins.
- Provides a debounced switch register with a change flag, and a free-running millisecond counter.
- Read data is combinational so the single-cycle core can load it in the same cycle; `sel` tells the core to mux it in place of RAM.

---
 rtl/mmio_de10.sv | 180 ++++++++++++++++++
 tb/tb_mmio_de10.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_de10.sv
// DE10-Lite memory-mapped I/O block: LEDs, six 7-segment digits, debounced switches
// with a change flag, and a free-running millisecond counter on the single-cycle data bus.
module mmio_de10 #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter logic [31:0] MMIO_BASE       = 32'hFFFF_FF00,
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  sel,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic [9:0]            sw,
    output logic [9:0]            ledr,
    output logic [7:0]            hex0,
    output logic [7:0]            hex1,
    output logic [7:0]            hex2,
    output logic [7:0]            hex3,
    output logic [7:0]            hex4,
    output logic [7:0]            hex5
);

    localparam int unsigned PRESCALE = CLK_HZ / 1000;
    localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [5:0] W_LED    = 6'h00;
    localparam logic [5:0] W_HEXVAL = 6'h01;
    localparam logic [5:0] W_BLANK  = 6'h02;
    localparam logic [5:0] W_SW     = 6'h03;
    localparam logic [5:0] W_MS     = 6'h04;
    localparam logic [5:0] W_SWCHG  = 6'h05;

    logic [9:0]            led_q,    led_d;
    logic [23:0]           hexval_q, hexval_d;
    logic [5:0]            blank_q,  blank_d;
    logic [9:0]            sync1_q,  sync2_q, prev_q;
    logic [9:0]            deb_q,    deb_d;
    logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
    logic [DATA_WIDTH-1:0] ms_q,     ms_d;
    logic [PS_W-1:0]       ps_q,     ps_d;
    logic                  swchg_q,  swchg_d;
    logic                  db_upd;
    logic                  wr;
    logic [5:0]            word;
    logic [7:0]            hex_c [6];
    logic                  unused_addr_bits;

    assign sel              = (data_addr[31:8] == MMIO_BASE[31:8]);
    assign word             = data_addr[7:2];
    assign wr               = mem_write && sel;
    assign unused_addr_bits = ^data_addr[1:0];

    // Next-state for every register; debounce update outranks a same-edge SWCHG clear.
    always_comb begin
        led_d    = led_q;
        hexval_d = hexval_q;
        blank_d  = blank_q;
        deb_d    = deb_q;
        db_cnt_d = db_cnt_q;
        ms_d     = ms_q;
        ps_d     = ps_q;
        swchg_d  = swchg_q;
        db_upd   = 1'b0;

        if (sync2_q != prev_q || sync2_q == deb_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d    = sync2_q;
            db_cnt_d = '0;
            db_upd   = 1'b1;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end

        if (wr && word == W_MS) begin
            ms_d = write_data;
            ps_d = '0;
        end else if (ps_q == PS_W'(PRESCALE - 1)) begin
            ps_d = '0;
            ms_d = ms_q + DATA_WIDTH'(1);
        end else begin
            ps_d = ps_q + PS_W'(1);
        end

        if (wr && word == W_LED)    led_d    = write_data[9:0];
        if (wr && word == W_HEXVAL) hexval_d = write_data[23:0];
        if (wr && word == W_BLANK)  blank_d  = write_data[5:0];

        if (db_upd) begin
            swchg_d = 1'b1;
        end else if (wr && word == W_SWCHG && write_data[0]) begin
            swchg_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q    <= '0;
            hexval_q <= '0;
            blank_q  <= 6'h3F;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            deb_q    <= '0;
            db_cnt_q <= '0;
            ms_q     <= '0;
            ps_q     <= '0;
            swchg_q  <= 1'b0;
        end else begin
            led_q    <= led_d;
            hexval_q <= hexval_d;
            blank_q  <= blank_d;
            sync1_q  <= sw;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            deb_q    <= deb_d;
            db_cnt_q <= db_cnt_d;
            ms_q     <= ms_d;
            ps_q     <= ps_d;
            swchg_q  <= swchg_d;
        end
    end

    // Combinational read path so the core can load in the same cycle.
    always_comb begin
        read_data = '0;
        if (sel) begin
            case (word)
                W_LED:    read_data = DATA_WIDTH'(led_q);
                W_HEXVAL: read_data = DATA_WIDTH'(hexval_q);
                W_BLANK:  read_data = DATA_WIDTH'(blank_q);
                W_SW:     read_data = DATA_WIDTH'(deb_q);
                W_MS:     read_data = ms_q;
                W_SWCHG:  read_data = DATA_WIDTH'(swchg_q);
                default:  read_data = '0;
            endcase
        end
    end

    // Active-low segments g..a for a hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            hex_c[k] = blank_q[k] ? 8'hFF : {1'b1, seg7(hexval_q[4*k +: 4])};
        end
    end

    assign ledr = led_q;
    assign hex0 = hex_c[0];
    assign hex1 = hex_c[1];
    assign hex2 = hex_c[2];
    assign hex3 = hex_c[3];
    assign hex4 = hex_c[4];
    assign hex5 = hex_c[5];

endmodule

// File: tb/tb_mmio_de10.sv
// Self-checking bench for mmio_de10: directed scenarios plus a randomized run
// compared against a behavioural model of the register file, switch debounce and ms counter.
module tb_mmio_de10;

    localparam int PS  = 4;
    localparam int DEB = 4;
    localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] data_addr;
    logic [31:0] write_data;
    logic        sel;
    logic [31:0] read_data;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [47:0] hex_all;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [9:0]  m_led;
    logic [23:0] m_hexval;
    logic [5:0]  m_blank;
    logic [9:0]  m_sw;
    logic [31:0] m_ms;
    int          m_ps;
    logic        m_swchg;
    logic [9:0]  pipe [$];
    logic [9:0]  last_s;
    int          run;

    assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

    always #5 clk = ~clk;

    mmio_de10 #(
        .DATA_WIDTH      (32),
        .MMIO_BASE       (32'hFFFF_FF00),
        .CLK_HZ          (4000),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .data_addr  (data_addr),
        .write_data (write_data),
        .sel        (sel),
        .read_data  (read_data),
        .sw         (sw),
        .ledr       (ledr),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5)
    );

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic [9:0] s;
        logic       upd;
        logic       in_win;
        if (reset) begin
            m_led = '0; m_hexval = '0; m_blank = 6'h3F; m_sw = '0;
            m_ms = '0; m_ps = 0; m_swchg = 1'b0;
            pipe.delete();
            pipe.push_back(10'h0);
            pipe.push_back(10'h0);
            last_s = '0;
            run = 1;
            return;
        end
        // Switches are seen two edges late; a value must be seen DEB+1 edges in a row.
        s = pipe.pop_front();
        pipe.push_back(sw);
        if (s == last_s) run++;
        else run = 1;
        last_s = s;
        upd = (run >= DEB + 1) && (s != m_sw);
        if (upd) m_sw = s;

        in_win = (data_addr[31:8] == 24'hFFFFFF);
        if (mem_write && in_win && data_addr[7:2] == 6'd4) begin
            m_ms = write_data;
            m_ps = 0;
        end else begin
            m_ps++;
            if (m_ps == PS) begin
                m_ps = 0;
                m_ms = m_ms + 32'd1;
            end
        end
        if (mem_write && in_win) begin
            case (data_addr[7:2])
                6'd0: m_led    = write_data[9:0];
                6'd1: m_hexval = write_data[23:0];
                6'd2: m_blank  = write_data[5:0];
                6'd5: if (write_data[0]) m_swchg = 1'b0;
                default: ;
            endcase
        end
        if (upd) m_swchg = 1'b1;
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a[31:8] != 24'hFFFFFF) return 32'h0;
        case (a[7:2])
            6'd0: return {22'h0, m_led};
            6'd1: return {8'h0, m_hexval};
            6'd2: return {26'h0, m_blank};
            6'd3: return {22'h0, m_sw};
            6'd4: return m_ms;
            6'd5: return {31'h0, m_swchg};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [47:0] exp_hex();
        logic [47:0] r;
        for (int k = 0; k < 6; k++) begin
            r[8*k +: 8] = m_blank[k] ? 8'hFF : GLYPH[m_hexval[4*k +: 4]];
        end
        return r;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        data_addr  = a;
        write_data = d;
        mem_write  = 1'b1;
        tick();
        mem_write  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_v [4];
        logic [31:0] addr_v [4];
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        addr_v = '{32'hFFFF_FF00, 32'hFFFF_FF04, 32'hFFFF_FF08, 32'hFFFF_FF14};
        exp_v  = '{32'h0, 32'h0, 32'h3F, 32'h0};
        for (int i = 0; i < 4; i++) begin
            data_addr = addr_v[i];
            #1;
            tests++;
            if (read_data !== exp_v[i]) begin
                fails++;
                $display("FAIL reset_read addr=%h got=%h exp=%h", addr_v[i], read_data, exp_v[i]);
            end
        end
        tests++;
        if (hex_all !== 48'hFFFF_FFFF_FFFF) begin
            fails++;
            $display("FAIL reset_hex got=%h exp=ffffffffffff", hex_all);
        end
        tests++;
        if (ledr !== 10'h0) begin
            fails++;
            $display("FAIL reset_ledr got=%h exp=000", ledr);
        end
    endtask

    task automatic test_led_hex();
        do_write(32'hFFFF_FF08, 32'h0);
        do_write(32'hFFFF_FF04, 32'h00A1_2F08);
        do_write(32'hFFFF_FF00, 32'hFFFF_FFFF);
        tests++;
        if (ledr !== 10'h3FF) begin
            fails++;
            $display("FAIL led_pins got=%h exp=3ff", ledr);
        end
        tests++;
        if (read_data !== 32'h3FF) begin
            fails++;
            $display("FAIL led_read got=%h exp=000003ff", read_data);
        end
        data_addr = 32'hFFFF_FF04;
        #1;
        tests++;
        if (read_data !== 32'h00A1_2F08) begin
            fails++;
            $display("FAIL hexval_read got=%h exp=00a12f08", read_data);
        end
        // Nibbles 8,0,F,2,1,A on hex0..hex5
        tests++;
        if (hex_all !== {8'h88, 8'hF9, 8'hA4, 8'h8E, 8'hC0, 8'h80}) begin
            fails++;
            $display("FAIL hex_glyphs got=%h exp=88f9a48ec080", hex_all);
        end
    endtask

    task automatic test_debounce();
        data_addr = 32'hFFFF_FF0C;
        sw = 10'h155;
        for (int i = 0; i < 6; i++) tick();
        tests++;
        if (read_data !== 32'h0) begin
            fails++;
            $display("FAIL deb_early got=%h exp=00000000", read_data);
        end
        tick();
        tests++;
        if (read_data !== 32'h155) begin
            fails++;
            $display("FAIL deb_latency got=%h exp=00000155", read_data);
        end
        data_addr = 32'hFFFF_FF14;
        #1;
        tests++;
        if (read_data !== 32'h1) begin
            fails++;
            $display("FAIL swchg_set got=%h exp=00000001", read_data);
        end
        sw = 10'h001;
        tick(); tick(); tick();
        sw = 10'h155;
        data_addr = 32'hFFFF_FF0C;
        for (int i = 0; i < 10; i++) tick();
        tests++;
        if (read_data !== 32'h155) begin
            fails++;
            $display("FAIL deb_glitch got=%h exp=00000155", read_data);
        end
    endtask

    task automatic test_swchg_race();
        do_write(32'hFFFF_FF14, 32'h1);
        tests++;
        if (read_data !== 32'h0) begin
            fails++;
            $display("FAIL swchg_clear got=%h exp=00000000", read_data);
        end
        sw = 10'h2AA;
        for (int i = 0; i < 6; i++) tick();
        do_write(32'hFFFF_FF14, 32'h1);
        tests++;
        if (read_data !== 32'h1) begin
            fails++;
            $display("FAIL swchg_race got=%h exp=00000001", read_data);
        end
        data_addr = 32'hFFFF_FF0C;
        #1;
        tests++;
        if (read_data !== 32'h2AA) begin
            fails++;
            $display("FAIL race_sw got=%h exp=000002aa", read_data);
        end
        do_write(32'hFFFF_FF14, 32'h0);
        tests++;
        if (read_data !== 32'h1) begin
            fails++;
            $display("FAIL swchg_w0 got=%h exp=00000001", read_data);
        end
        do_write(32'hFFFF_FF14, 32'h1);
        tests++;
        if (read_data !== 32'h0) begin
            fails++;
            $display("FAIL swchg_w1 got=%h exp=00000000", read_data);
        end
    endtask

    task automatic test_ms();
        do_write(32'hFFFF_FF10, 32'hFFFF_FFFE);
        tests++;
        if (read_data !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL ms_load got=%h exp=fffffffe", read_data);
        end
        tick(); tick(); tick();
        tests++;
        if (read_data !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL ms_hold got=%h exp=fffffffe", read_data);
        end
        tick();
        tests++;
        if (read_data !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL ms_inc got=%h exp=ffffffff", read_data);
        end
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (read_data !== 32'h0) begin
            fails++;
            $display("FAIL ms_wrap got=%h exp=00000000", read_data);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (read_data !== 32'h0) begin
            fails++;
            $display("FAIL ms_reset got=%h exp=00000000", read_data);
        end
        tick(); tick(); tick();
        tests++;
        if (read_data !== 32'h0) begin
            fails++;
            $display("FAIL ms_prescale_restart got=%h exp=00000000", read_data);
        end
        tick();
        tests++;
        if (read_data !== 32'h1) begin
            fails++;
            $display("FAIL ms_first_tick got=%h exp=00000001", read_data);
        end
    endtask

    task automatic test_decode();
        do_write(32'hFFFF_FF00, 32'h2A5);
        data_addr = 32'h0000_1000;
        #1;
        tests++;
        if (sel !== 1'b0 || read_data !== 32'h0) begin
            fails++;
            $display("FAIL decode_out sel=%b rd=%h exp sel=0 rd=00000000", sel, read_data);
        end
        do_write(32'h0000_1000, 32'hFFFF_FFFF);
        tests++;
        if (ledr !== 10'h2A5) begin
            fails++;
            $display("FAIL decode_out_write ledr=%h exp=2a5", ledr);
        end
        data_addr = 32'hFFFF_FF3C;
        #1;
        tests++;
        if (sel !== 1'b1 || read_data !== 32'h0) begin
            fails++;
            $display("FAIL decode_hole sel=%b rd=%h exp sel=1 rd=00000000", sel, read_data);
        end
        do_write(32'hFFFF_FF3C, 32'hFFFF_FFFF);
        do_write(32'hFFFF_FF0C, 32'h3FF);
        for (int w = 0; w < 6; w++) begin
            data_addr = 32'hFFFF_FF00 | 32'(w * 4);
            #1;
            tests++;
            if (read_data !== exp_read(data_addr)) begin
                fails++;
                $display("FAIL decode_regs addr=%h got=%h exp=%h", data_addr, read_data, exp_read(data_addr));
            end
        end
        tests++;
        if (ledr !== 10'h2A5 || hex_all !== exp_hex()) begin
            fails++;
            $display("FAIL decode_pins ledr=%h hex=%h exp ledr=2a5 hex=%h", ledr, hex_all, exp_hex());
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
            r = $urandom_range(0, 9);
            if (r >= 8) data_addr = $urandom;
            else data_addr = {24'hFFFFFF, 3'b000, 3'(r), 2'($urandom)};
            mem_write  = ($urandom_range(0, 2) == 0);
            write_data = $urandom;
            tick();
            mem_write = 1'b0;
            tests++;
            if (sel !== (data_addr[31:8] == 24'hFFFFFF)) begin
                fails++;
                $display("FAIL rnd_sel addr=%h got=%b", data_addr, sel);
            end
            tests++;
            if (read_data !== exp_read(data_addr)) begin
                fails++;
                $display("FAIL rnd_read it=%0d addr=%h got=%h exp=%h", i, data_addr, read_data, exp_read(data_addr));
            end
            tests++;
            if (ledr !== m_led) begin
                fails++;
                $display("FAIL rnd_ledr it=%0d got=%h exp=%h", i, ledr, m_led);
            end
            tests++;
            if (hex_all !== exp_hex()) begin
                fails++;
                $display("FAIL rnd_hex it=%0d got=%h exp=%h", i, hex_all, exp_hex());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        mem_write  = 1'b0;
        data_addr  = 32'h0;
        write_data = 32'h0;
        sw         = 10'h0;
        test_reset();
        test_led_hex();
        test_debounce();
        test_swchg_race();
        test_ms();
        test_decode();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
